// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter; define SERIAL_TX_PARITY_EN to add an even-parity bit
module serial_tx #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_uart_tx,
    output logic       o_busy
);
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state = IDLE, state_n;
    logic [23:0] cnt = '0, cnt_n;
    logic [2:0] idx = '0, idx_n;
    logic [7:0] sh = '0, sh_n;
    logic tx = 1'b1, tx_n;
    logic busy = 1'b0, busy_n;
    logic tick;
`ifdef SERIAL_TX_PARITY_EN
    logic par = 1'b0, par_n;
`endif
    assign tick = cnt == '0;
    assign o_uart_tx = tx;
    assign o_busy = busy;
    // next-state and next line value; the line is registered so it never glitches
    always_comb begin
        state_n = state;
        cnt_n = tick ? CLOCKS_PER_BAUD - 24'd1 : cnt - 24'd1;
        idx_n = idx;
        sh_n = sh;
        tx_n = tx;
        busy_n = busy;
`ifdef SERIAL_TX_PARITY_EN
        par_n = par;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (i_wr) begin
                    state_n = START;
                    cnt_n = CLOCKS_PER_BAUD - 24'd1;
                    sh_n = i_data;
                    tx_n = 1'b0;
                    busy_n = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    par_n = ^i_data;
`endif
                end
            end
            START: if (tick) begin
                state_n = DATA;
                idx_n = '0;
                tx_n = sh[0];
            end
            DATA: if (tick) begin
                if (idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_n = PARITY;
                    tx_n = par;
`else
                    state_n = STOP;
                    tx_n = 1'b1;
`endif
                end else begin
                    idx_n = idx + 3'd1;
                    sh_n = sh >> 1;
                    tx_n = sh[1];
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (tick) begin
                state_n = STOP;
                tx_n = 1'b1;
            end
`endif
            STOP: if (tick) begin
                state_n = IDLE;
                cnt_n = '0;
                tx_n = 1'b1;
                busy_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    // state register; reset abandons any frame and returns the line to idle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            tx <= 1'b1;
            busy <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            tx <= tx_n;
            busy <= busy_n;
`ifdef SERIAL_TX_PARITY_EN
            par <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed frame vectors plus random traffic checked by a receiver model
module tb_serial_tx;
    localparam int CPB = 4;
    localparam int BIG = 868;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    typedef struct packed {
        logic [7:0] d;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, wr = 1'b0, wr2 = 1'b0;
    logic [7:0] data = '0, data2 = '0;
    logic tx, busy, tx2, busy2;
    vec_t vt[10];
    int n_vec = 0, n_bad = 0;
    logic [7:0] q[$];
    bit rx_en = 0;
    int rx_off = -1, rx_n;
    logic [7:0] rx_b = '0;
    logic acc_q = 1'b0, busy_d = 1'b0;

    serial_tx #(.CLOCKS_PER_BAUD(24'd4)) dut (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(data),
        .o_uart_tx(tx), .o_busy(busy)
    );
    serial_tx #(.CLOCKS_PER_BAUD(24'd868)) dut_big (
        .i_clk(clk), .i_reset(rst), .i_wr(wr2), .i_data(data2),
        .o_uart_tx(tx2), .o_busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic expb(input int v, input int b);
        if (b < 9) return vt[v].frame[b];
`ifdef SERIAL_TX_PARITY_EN
        if (b == 9) return vt[v].par;
`endif
        return vt[v].frame[9];
    endfunction

    task automatic tick1;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] d);
        wr = 1'b1;
        data = d;
        tick1();
        wr = 1'b0;
        data = ~d;
    endtask

    task automatic check_frame(input int v, input int poke, input int stop_at);
        for (int i = 0; i < NB * CPB; i++) begin
            if (i == stop_at) return;
            chk($sformatf("%02h tx@%0d", vt[v].d, i), 32'(tx), 32'(expb(v, i / CPB)));
            chk($sformatf("%02h busy@%0d", vt[v].d, i), 32'(busy), 32'd1);
            if (i == poke) begin
                wr = 1'b1;
                data = 8'hFF;
            end
            tick1();
            if (i == poke) wr = 1'b0;
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " tx"}, 32'(tx), 32'd1);
    endtask

    // acceptance as seen on the pins, used to police busy rising
    always @(posedge clk) acc_q <= wr && !busy && !rst;

    always @(negedge clk) begin
        if (busy && !busy_d) chk("busy rise without accept", 32'(acc_q), 32'd1);
        busy_d = busy;
    end

    // receiver model sampling mid-bit, counted from the first low sample
    always @(negedge clk) if (rx_en) begin
        if (rx_off < 0) begin
            if (!tx) rx_off = 0;
        end else begin
            rx_off++;
            if (rx_off % CPB == CPB / 2) begin
                rx_n = rx_off / CPB;
                if (rx_n == 0) chk("rx start", 32'(tx), 32'd0);
                else if (rx_n <= 8) rx_b[rx_n - 1] = tx;
                else if (rx_n < NB - 1) chk("rx parity", 32'(tx), 32'(^rx_b));
                else begin
                    chk("rx stop", 32'(tx), 32'd1);
                    if (q.size() == 0) chk("rx unexpected byte", 32'(rx_b), 32'hFFFF);
                    else chk("rx byte", 32'(rx_b), 32'(q.pop_front()));
                    rx_off = -1;
                end
            end
        end
    end

    initial begin
        int t;
        logic [7:0] d;
        vt[0] = '{8'h55, 10'b1010101010, 1'b0};
        vt[1] = '{8'h30, 10'b1001100000, 1'b0};
        vt[2] = '{8'h78, 10'b1011110000, 1'b0};
        vt[3] = '{8'h00, 10'b1000000000, 1'b0};
        vt[4] = '{8'hA3, 10'b1101000110, 1'b0};
        vt[5] = '{8'h0D, 10'b1000011010, 1'b1};
        vt[6] = '{8'hFF, 10'b1111111110, 1'b0};
        vt[7] = '{8'h07, 10'b1000001110, 1'b1};
        vt[8] = '{8'h03, 10'b1000000110, 1'b0};
        vt[9] = '{8'hA5, 10'b1101001010, 1'b0};
        tick1();
        tick1();
        check_idle("reset");
        rst = 1'b0;
        tick1();
        check_idle("post reset");
        for (int v = 0; v < 10; v++) begin
            accept(vt[v].d);
            check_frame(v, -1, -1);
            check_idle("after frame");
        end
        wr = 1'b1;
        data = 8'h30;
        tick1();
        data = 8'h78;
        check_frame(1, -1, -1);
        check_idle("b2b gap");
        tick1();
        check_frame(2, -1, -1);
        wr = 1'b0;
        check_idle("b2b end");
        accept(8'h00);
        check_frame(3, 4 * CPB + 2, -1);
        for (int i = 0; i < 6; i++) begin
            check_idle("ignored wr");
            tick1();
        end
        accept(8'hA3);
        check_frame(4, -1, 6 * CPB + 1);
        rst = 1'b1;
        wr = 1'b1;
        data = 8'h55;
        tick1();
        check_idle("mid reset");
        tick1();
        check_idle("held reset");
        rst = 1'b0;
        wr = 1'b0;
        tick1();
        check_idle("reset release");
        accept(8'h0D);
        check_frame(5, -1, -1);
        check_idle("after reset frame");
        rx_en = 1;
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 5)) tick1();
            d = 8'($urandom);
            wr = 1'b1;
            data = d;
            t = 0;
            do begin
                tick1();
                t++;
            end while (!acc_q && t < 200);
            chk("rand accept", 32'(acc_q), 32'd1);
            q.push_back(d);
            wr = 1'b0;
            data = 8'($urandom);
        end
        repeat (NB * CPB + 10) tick1();
        chk("rx queue drained", q.size(), 0);
        rx_en = 0;
        wr2 = 1'b1;
        data2 = 8'hA5;
        tick1();
        wr2 = 1'b0;
        data2 = 8'h00;
        chk("big busy", 32'(busy2), 32'd1);
        for (int i = 0; i < NB * BIG; i++) begin
            if (i % BIG == BIG / 2)
                chk($sformatf("big bit %0d", i / BIG), 32'(tx2), 32'(expb(9, i / BIG)));
            tick1();
        end
        chk("big busy end", 32'(busy2), 32'd0);
        chk("big tx end", 32'(tx2), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
